// File: rtl/shift_sequencer.sv
// Byte-serial shift/rotate engine: one 8-bit funnel stage produces one result byte per cycle.
// Optional macro SHIFT_SEQ_ZERO_BYPASS_EN: zero-amount requests skip the RUN phase.

module shift_funnel8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] n,
  output logic [7:0] y
);
  assign y = 8'({a, b} >> n);
endmodule

module shift_sequencer #(
  parameter int BYTES = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*BYTES-1:0]           in_data,
  input  logic [$clog2(8*BYTES)-1:0]   in_amt,
  input  logic [1:0]                   in_op,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [8*BYTES-1:0]           out_data
);
  localparam int W  = 8 * BYTES;
  localparam int AW = $clog2(W);
  localparam int JW = $clog2(BYTES);
  localparam int KW = AW - 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_LSR, OP_ASR, OP_LSL, OP_ROR} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   out_q, out_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2:0]     s_q, s_d;
  logic [JW-1:0]  j_q, j_d;

  int             a_idx, b_idx;
  logic [7:0]     fun_a, fun_b, fun_y;
  logic [3:0]     fun_n;

  // Byte i of the latched operand, with out-of-range indices resolved by the op's fill rule.
  function automatic logic [7:0] src_byte(input logic [W-1:0] d, input op_t op, input int idx);
    int widx;
    widx = ((idx % BYTES) + BYTES) % BYTES;
    if (op == OP_ROR)                 return d[8*widx +: 8];
    else if (idx >= 0 && idx < BYTES) return d[8*idx +: 8];
    else if (op == OP_ASR)            return {8{d[W-1]}};
    else                              return 8'h00;
  endfunction

  always_comb begin
    if (op_q == OP_LSL) begin
      a_idx = int'(j_q) - int'(k_q);
      b_idx = a_idx - 1;
      fun_n = 4'd8 - {1'b0, s_q};
    end else begin
      b_idx = int'(j_q) + int'(k_q);
      a_idx = b_idx + 1;
      fun_n = {1'b0, s_q};
    end
    fun_a = src_byte(data_q, op_q, a_idx);
    fun_b = src_byte(data_q, op_q, b_idx);
  end

  shift_funnel8 u_funnel (
    .a (fun_a),
    .b (fun_b),
    .n (fun_n),
    .y (fun_y)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    out_d   = out_q;
    k_d     = k_q;
    s_d     = s_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = op_t'(in_op);
          k_d     = in_amt[AW-1:3];
          s_d     = in_amt[2:0];
          j_d     = '0;
          out_d   = '0;
          state_d = RUN;
`ifdef SHIFT_SEQ_ZERO_BYPASS_EN
          if (in_amt == '0) begin
            out_d   = in_data;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        out_d[8*j_q +: 8] = fun_y;
        j_d = j_q + 1'b1;
        if (j_q == JW'(BYTES - 1)) begin
          j_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= OP_LSR;
      data_q  <= '0;
      out_q   <= '0;
      k_q     <= '0;
      s_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      out_q   <= out_d;
      k_q     <= k_d;
      s_q     <= s_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

endmodule
